// File: rtl/issue_queue_mem_ordered.sv
// Collapsing, age-ordered issue queue with memory-ordering rules.
// Stores wait for every older entry; loads wait only for older stores.
// Latency: an entry enqueued at the edge ending cycle t can issue in t+1.
// Backpressure: in_ready comes from the registered count only. Busy issue ports are skipped.
//
// Ports:
//   clock, reset               sync active-high reset; flush drops every entry
//   in_*                       DISPATCH_W dispatch lanes (valid, store flag, payload, tags, ready bits)
//   in_ready                   room for a full dispatch group
//   ctb_valid/ctb_tag          CTB_W wakeup broadcasts
//   ex_busy                    per issue port: port cannot take a uop this cycle
//   out_valid/out_is_store/out_payload   ISSUE_W issue ports
//   count                      occupied slots
module issue_queue_mem_ordered #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 4,
  parameter int ISSUE_W    = 2,
  parameter int CTB_W      = 4,
  parameter int TAG_W      = 6,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [DISPATCH_W-1:0]                in_valid,
  input  logic [DISPATCH_W-1:0]                in_is_store,
  input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] in_payload,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]     in_rs1_tag,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]     in_rs2_tag,
  input  logic [DISPATCH_W-1:0]                in_rs1_rdy,
  input  logic [DISPATCH_W-1:0]                in_rs2_rdy,
  output logic                                 in_ready,
  input  logic [CTB_W-1:0]                     ctb_valid,
  input  logic [CTB_W-1:0][TAG_W-1:0]          ctb_tag,
  input  logic [ISSUE_W-1:0]                   ex_busy,
  output logic [ISSUE_W-1:0]                   out_valid,
  output logic [ISSUE_W-1:0]                   out_is_store,
  output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    out_payload,
  output logic [$clog2(DEPTH):0]               count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Slot state; slot 0 is the oldest entry and valid slots are contiguous from 0.
  logic [DEPTH-1:0]                slot_valid, nxt_valid;
  logic [DEPTH-1:0]                slot_store, nxt_store;
  logic [DEPTH-1:0]                slot_rdy1,  nxt_rdy1;
  logic [DEPTH-1:0]                slot_rdy2,  nxt_rdy2;
  logic [DEPTH-1:0][TAG_W-1:0]     slot_tag1,  nxt_tag1;
  logic [DEPTH-1:0][TAG_W-1:0]     slot_tag2,  nxt_tag2;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] slot_pl,    nxt_pl;
  logic [CNT_W-1:0]                nxt_count;

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] issued;
  logic             block_issue;

  // Returns 1 when any valid broadcast lane carries this tag.
  function automatic logic woke(input logic [TAG_W-1:0]            tag,
                                input logic [CTB_W-1:0]            cv,
                                input logic [CTB_W-1:0][TAG_W-1:0] ct);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CTB_W; c++) begin
      if (cv[c] && (ct[c] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign in_ready    = (CNT_W'(DEPTH) - count) >= CNT_W'(DISPATCH_W);
  assign block_issue = reset | flush;

  // Eligibility uses registered slot state only. A slot issued this cycle still
  // blocks younger entries until it has left the queue.
  always_comb begin
    logic seen_valid;
    logic seen_store;
    seen_valid = 1'b0;
    seen_store = 1'b0;
    eligible   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = slot_valid[i] && slot_rdy1[i] && slot_rdy2[i] &&
                    (slot_store[i] ? !seen_valid : !seen_store);
      seen_valid  = seen_valid | slot_valid[i];
      seen_store  = seen_store | (slot_valid[i] & slot_store[i]);
    end
  end

  // Oldest-first selection. Each free port, in ascending index, takes the oldest
  // eligible slot that no lower port has already claimed.
  always_comb begin
    logic found;
    out_valid    = '0;
    out_is_store = '0;
    out_payload  = '0;
    issued       = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && !block_issue && !ex_busy[p] && eligible[i] && !issued[i]) begin
          found          = 1'b1;
          issued[i]      = 1'b1;
          out_valid[p]   = 1'b1;
          out_is_store[p] = slot_store[i];
          out_payload[p] = slot_pl[i];
        end
      end
    end
  end

  // Next state: survivors shift down in age order and pick up this cycle's
  // wakeups. The accepted dispatch lanes are appended behind them in lane order.
  always_comb begin
    logic [CNT_W-1:0] pos;
    pos       = '0;
    nxt_valid = '0;
    nxt_store = '0;
    nxt_rdy1  = '0;
    nxt_rdy2  = '0;
    nxt_tag1  = '0;
    nxt_tag2  = '0;
    nxt_pl    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && !issued[i]) begin
        nxt_valid[pos[IDX_W-1:0]] = 1'b1;
        nxt_store[pos[IDX_W-1:0]] = slot_store[i];
        nxt_tag1[pos[IDX_W-1:0]]  = slot_tag1[i];
        nxt_tag2[pos[IDX_W-1:0]]  = slot_tag2[i];
        nxt_pl[pos[IDX_W-1:0]]    = slot_pl[i];
        nxt_rdy1[pos[IDX_W-1:0]]  = slot_rdy1[i] | woke(slot_tag1[i], ctb_valid, ctb_tag);
        nxt_rdy2[pos[IDX_W-1:0]]  = slot_rdy2[i] | woke(slot_tag2[i], ctb_valid, ctb_tag);
        pos = pos + CNT_W'(1);
      end
    end
    if (in_ready) begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (in_valid[l] && (pos < CNT_W'(DEPTH))) begin
          nxt_valid[pos[IDX_W-1:0]] = 1'b1;
          nxt_store[pos[IDX_W-1:0]] = in_is_store[l];
          nxt_tag1[pos[IDX_W-1:0]]  = in_rs1_tag[l];
          nxt_tag2[pos[IDX_W-1:0]]  = in_rs2_tag[l];
          nxt_pl[pos[IDX_W-1:0]]    = in_payload[l];
          // A broadcast in the enqueue cycle itself also counts.
          nxt_rdy1[pos[IDX_W-1:0]]  = in_rs1_rdy[l] | woke(in_rs1_tag[l], ctb_valid, ctb_tag);
          nxt_rdy2[pos[IDX_W-1:0]]  = in_rs2_rdy[l] | woke(in_rs2_tag[l], ctb_valid, ctb_tag);
          pos = pos + CNT_W'(1);
        end
      end
    end
    nxt_count = pos;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      slot_valid <= '0;
      count      <= '0;
    end else begin
      slot_valid <= nxt_valid;
      slot_store <= nxt_store;
      slot_rdy1  <= nxt_rdy1;
      slot_rdy2  <= nxt_rdy2;
      slot_tag1  <= nxt_tag1;
      slot_tag2  <= nxt_tag2;
      slot_pl    <= nxt_pl;
      count      <= nxt_count;
    end
  end

endmodule

// File: tb/tb_issue_queue_mem_ordered.sv
// Directed bench for issue_queue_mem_ordered with default parameters.
// Stimulus pushes the expected (cycle, port, store, payload) of every issue.
// A negedge monitor pops and compares each presented issue.
module tb_issue_queue_mem_ordered;

  logic               clock;
  logic               reset;
  logic               flush;
  logic [3:0]         in_valid;
  logic [3:0]         in_is_store;
  logic [3:0][63:0]   in_payload;
  logic [3:0][5:0]    in_rs1_tag;
  logic [3:0][5:0]    in_rs2_tag;
  logic [3:0]         in_rs1_rdy;
  logic [3:0]         in_rs2_rdy;
  logic               in_ready;
  logic [3:0]         ctb_valid;
  logic [3:0][5:0]    ctb_tag;
  logic [1:0]         ex_busy;
  logic [1:0]         out_valid;
  logic [1:0]         out_is_store;
  logic [1:0][63:0]   out_payload;
  logic [4:0]         count;

  issue_queue_mem_ordered dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_is_store(in_is_store), .in_payload(in_payload),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
    .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_ready(in_ready), .ctb_valid(ctb_valid), .ctb_tag(ctb_tag),
    .ex_busy(ex_busy), .out_valid(out_valid), .out_is_store(out_is_store),
    .out_payload(out_payload), .count(count)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic        st;
    logic [63:0] pl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    flush       = 1'b0;
    in_valid    = '0;
    in_is_store = '0;
    in_payload  = '0;
    in_rs1_tag  = '0;
    in_rs2_tag  = '0;
    in_rs1_rdy  = '0;
    in_rs2_rdy  = '0;
    ctb_valid   = '0;
    ctb_tag     = '0;
  endtask

  task automatic set_lane(input int l, input logic st, input logic [63:0] pl,
                          input logic [5:0] t1, input logic r1,
                          input logic [5:0] t2, input logic r2);
    in_valid[l]    = 1'b1;
    in_is_store[l] = st;
    in_payload[l]  = pl;
    in_rs1_tag[l]  = t1;
    in_rs1_rdy[l]  = r1;
    in_rs2_tag[l]  = t2;
    in_rs2_rdy[l]  = r2;
  endtask

  task automatic bcast(input int lane, input logic [5:0] tag);
    ctb_valid[lane] = 1'b1;
    ctb_tag[lane]   = tag;
  endtask

  task automatic expect_issue(input int c, input int p, input logic st, input logic [63:0] pl);
    exp_t e;
    e.cyc = c; e.port = p; e.st = st; e.pl = pl;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented issue must match the oldest outstanding expectation.
  always @(negedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (out_valid[p] !== 1'b0) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue: cyc=%0d port=%0d payload=%0h, expected no issue",
                   cyc, p, out_payload[p]);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != cyc || mon_e.port != p || mon_e.st !== out_is_store[p] ||
              mon_e.pl !== out_payload[p]) begin
            n_fail++;
            $display("FAIL issue: got cyc=%0d port=%0d store=%0b payload=%0h, expected cyc=%0d port=%0d store=%0b payload=%0h",
                     cyc, p, out_is_store[p], out_payload[p], mon_e.cyc, mon_e.port, mon_e.st, mon_e.pl);
          end
        end
      end
    end
  end

  initial begin
    clr();
    ex_busy = '0;
    reset   = 1'b1;
    tick();
    tick();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;

    // Four ready loads: two issue per cycle, oldest first.
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 64'h100 + 64'(l), 6'd0, 1'b1, 6'd0, 1'b1);
    expect_issue(cyc + 1, 0, 1'b0, 64'h100);
    expect_issue(cyc + 1, 1, 1'b0, 64'h101);
    expect_issue(cyc + 2, 0, 1'b0, 64'h102);
    expect_issue(cyc + 2, 1, 1'b0, 64'h103);
    tick(); clr();
    chk("burst_count_4", 64'(count), 64'd4);
    tick();
    chk("burst_count_2", 64'(count), 64'd2);
    tick();
    chk("burst_count_0", 64'(count), 64'd0);

    // Load waiting on tag 5: an unrelated tag leaves it asleep, and tag 5 wakes it for the next cycle.
    set_lane(0, 1'b0, 64'h200, 6'd5, 1'b0, 6'd0, 1'b1);
    tick(); clr();
    bcast(1, 6'd7);
    tick(); clr();
    bcast(2, 6'd5);
    expect_issue(cyc + 1, 0, 1'b0, 64'h200);
    tick(); clr();
    tick();
    chk("wake_count_0", 64'(count), 64'd0);

    // A wakeup in the enqueue cycle itself readies both operands.
    set_lane(0, 1'b0, 64'h280, 6'd12, 1'b0, 6'd12, 1'b0);
    bcast(3, 6'd12);
    expect_issue(cyc + 1, 0, 1'b0, 64'h280);
    tick(); clr();
    tick();
    chk("enq_wake_count_0", 64'(count), 64'd0);

    // An unready store blocks a younger ready load. After the store issues, the load follows one cycle later.
    set_lane(0, 1'b1, 64'h300, 6'd9, 1'b0, 6'd0, 1'b1);
    set_lane(1, 1'b0, 64'h301, 6'd0, 1'b1, 6'd0, 1'b1);
    tick(); clr();
    bcast(0, 6'd9);
    expect_issue(cyc + 1, 0, 1'b1, 64'h300);
    expect_issue(cyc + 2, 0, 1'b0, 64'h301);
    tick(); clr();
    chk("st_ld_count_2", 64'(count), 64'd2);
    tick();
    chk("st_ld_count_1", 64'(count), 64'd1);
    tick();
    chk("st_ld_count_0", 64'(count), 64'd0);

    // A ready store waits behind an older unready load.
    set_lane(0, 1'b0, 64'h310, 6'd10, 1'b0, 6'd0, 1'b1);
    set_lane(1, 1'b1, 64'h311, 6'd0, 1'b1, 6'd0, 1'b1);
    tick(); clr();
    bcast(0, 6'd10);
    expect_issue(cyc + 1, 0, 1'b0, 64'h310);
    expect_issue(cyc + 2, 0, 1'b1, 64'h311);
    tick(); clr();
    tick();
    tick();
    chk("ld_st_count_0", 64'(count), 64'd0);

    // Fill 13 sleeping entries. The queue then refuses a dispatch group until one entry leaves.
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 4; l++) begin
        if (g * 4 + l < 13)
          set_lane(l, 1'b0, 64'h400 + 64'(g * 4 + l), (g == 0 && l == 0) ? 6'd21 : 6'd20,
                   1'b0, 6'd0, 1'b1);
      end
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      tick(); clr();
    end
    chk("full_count_13", 64'(count), 64'd13);
    chk("full_in_ready_0", 64'(in_ready), 64'd0);
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 64'h4ff, 6'd0, 1'b1, 6'd0, 1'b1);
    tick(); clr();
    chk("full_ignored_count", 64'(count), 64'd13);
    bcast(0, 6'd21);
    expect_issue(cyc + 1, 0, 1'b0, 64'h400);
    tick(); clr();
    chk("full_pre_issue_count", 64'(count), 64'd13);
    tick();
    chk("full_count_12", 64'(count), 64'd12);
    chk("full_in_ready_1", 64'(in_ready), 64'd1);
    bcast(0, 6'd20);
    for (int i = 0; i < 12; i++) expect_issue(cyc + 1 + i / 2, i % 2, 1'b0, 64'h401 + 64'(i));
    tick(); clr();
    repeat (6) tick();
    chk("drain_count_0", 64'(count), 64'd0);

    // With port 0 busy, both entries go out on port 1, oldest first.
    set_lane(0, 1'b0, 64'h500, 6'd0, 1'b1, 6'd0, 1'b1);
    set_lane(1, 1'b0, 64'h501, 6'd0, 1'b1, 6'd0, 1'b1);
    tick(); clr();
    ex_busy = 2'b01;
    expect_issue(cyc, 1, 1'b0, 64'h500);
    expect_issue(cyc + 1, 1, 1'b0, 64'h501);
    #1;
    chk("busy_port0_idle", 64'(out_valid[0]), 64'd0);
    tick();
    tick();
    ex_busy = 2'b00;
    chk("busy_count_0", 64'(count), 64'd0);

    // Flush with 8 ready entries, a valid dispatch group and a wakeup: nothing issues and all entries are dropped.
    ex_busy = 2'b11;
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 64'h600 + 64'(g * 4 + l), 6'd0, 1'b1, 6'd0, 1'b1);
      tick(); clr();
    end
    chk("pre_flush_count_8", 64'(count), 64'd8);
    ex_busy = 2'b00;
    flush   = 1'b1;
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 64'h6f0, 6'd0, 1'b1, 6'd0, 1'b1);
    bcast(0, 6'd3);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick(); clr();
    chk("flush_count_0", 64'(count), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    chk("post_flush_count_0", 64'(count), 64'd0);

    // Reset in the middle of operation drops ready entries with no issue that cycle.
    ex_busy = 2'b11;
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 64'h700 + 64'(l), 6'd0, 1'b1, 6'd0, 1'b1);
    tick(); clr();
    chk("pre_reset_count_4", 64'(count), 64'd4);
    ex_busy = 2'b00;
    reset   = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    chk("midreset_count_0", 64'(count), 64'd0);
    tick();
    tick();
    chk("post_reset_count_0", 64'(count), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue_mem_ordered.md
ISSUE_QUEUE_MEM_ORDERED -- requirements
Module: issue_queue_mem_ordered

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of queue slots (power of 2, >= DISPATCH_W).
REQ-002 The block SHALL have parameter DISPATCH_W, default 4, meaning dispatch lanes per cycle.
REQ-003 The block SHALL have parameter ISSUE_W, default 2, meaning issue ports per cycle.
REQ-004 The block SHALL have parameter CTB_W, default 4, meaning common tag bus broadcast lanes.
REQ-005 The block SHALL have parameter TAG_W, default 6, meaning physical register index width.
REQ-006 The block SHALL have parameter PAYLOAD_W, default 64, meaning opaque uop payload width.
REQ-007 The block SHALL have ports clock (in, 1, clock) and reset (in, 1, reset); reset is synchronous, active-high.
REQ-008 The block SHALL have port flush (in, 1): discard all entries.
REQ-009 The block SHALL have ports in_valid (in, DISPATCH_W), in_is_store (in, DISPATCH_W), in_payload (in, DISPATCH_W x PAYLOAD_W).
REQ-010 The block SHALL have ports in_rs1_tag, in_rs2_tag (in, DISPATCH_W x TAG_W) and in_rs1_rdy, in_rs2_rdy (in, DISPATCH_W): operand already available.
REQ-011 The block SHALL have port in_ready (out, 1): queue accepts a full dispatch group this cycle.
REQ-012 The block SHALL have ports ctb_valid (in, CTB_W) and ctb_tag (in, CTB_W x TAG_W): wakeup broadcasts.
REQ-013 The block SHALL have port ex_busy (in, ISSUE_W): issue port cannot accept this cycle.
REQ-014 The block SHALL have ports out_valid (out, ISSUE_W), out_is_store (out, ISSUE_W), out_payload (out, ISSUE_W x PAYLOAD_W).
REQ-015 The block SHALL have port count (out, clog2(DEPTH)+1): occupied slots.

Function
REQ-016 Slots SHALL be age-ordered: slot 0 oldest, valid slots contiguous from 0 (collapsing queue).
REQ-017 in_ready SHALL equal (DEPTH - count) >= DISPATCH_W, from registered count only.
REQ-018 When in_ready=1, lanes with in_valid=1 SHALL be written in lane order to slots directly after the post-issue compacted survivors; invalid lanes occupy no slot; when in_ready=0 all lanes are ignored.
REQ-019 An entry's operand SHALL be ready if its rdy bit was set, or any ctb lane with ctb_valid=1 carried its tag in any cycle since (including the enqueue cycle itself).
REQ-020 An entry SHALL be eligible when both operands ready and: store -> no older valid entry exists; load -> no older valid store exists.
REQ-021 Selection SHALL be combinational from registered state: eligible entries, oldest first, assigned to non-busy ports in ascending port index; busy ports get out_valid=0.
REQ-022 Eligibility SHALL be evaluated on registered state only; an entry issued in cycle t does not unblock younger entries until t+1.
REQ-023 Issued entries SHALL be removed at the clock edge ending the issue cycle; survivors shift down preserving order, ready bits travelling with them.
REQ-024 count SHALL update as count + accepted - issued; never exceeds DEPTH, never underflows.
REQ-025 A ctb wakeup in cycle t SHALL make an entry selectable no earlier than t+1.
REQ-026 flush=1 SHALL force out_valid=0 that cycle, clear all slots and count at the edge, and ignore enqueue that cycle.
REQ-027 flush and reset SHALL take priority over enqueue, issue and wakeup.

Reset
REQ-028 On reset all slots SHALL be invalid, count=0, in_ready=1, out_valid=0, out_is_store=0, out_payload=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries in one cycle with no issue that cycle.

Verification
REQ-030 Reset, enqueue 4 loads all rdy, ex_busy=0 -> next cycle out_valid=2'b11 slots 0,1; following cycle slots 2,3; count 4->2->0.
REQ-031 Load tag 5 not ready; ctb tag 5 in cycle t -> load issues in t+1, not t.
REQ-032 Store(rs1 unready) then ready load -> load blocked; wake store -> store issues alone, load issues the next cycle.
REQ-033 Fill with 13 entries (DEPTH=16) -> in_ready=0, dispatch ignored, count stays 13; issue 1 -> count 12, in_ready=1.
REQ-034 ex_busy=2'b01 with 2 eligible -> oldest on port 1 only, port 0 out_valid=0.
REQ-035 8 entries, flush with valid dispatch -> out_valid=0, next cycle count=0, in_ready=1.
